// File: rtl/icw_ocw_control_pkg.sv
// Shared types and bit positions for the 8259 ICW/OCW control slice.
package pic_pkg;

   // Initialization sequencing states
   typedef enum logic [2:0] {
      UNINIT    = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } pic_state_t;

   // Position of each write flag inside the registered flag vector
   localparam int FLAG_ICW1   = 0;
   localparam int FLAG_ICW2_4 = 1;
   localparam int FLAG_OCW1   = 2;
   localparam int FLAG_OCW2   = 3;
   localparam int FLAG_OCW3   = 4;
   localparam int NUM_FLAGS   = 5;

   // ICW1 bits
   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_ADI  = 2;
   localparam int ICW1_LTIM = 3;

   // ICW4 bits
   localparam int ICW4_UPM  = 0;
   localparam int ICW4_AEOI = 1;
   localparam int ICW4_MS   = 2;
   localparam int ICW4_BUF  = 3;
   localparam int ICW4_SFNM = 4;

   // OCW3 bits
   localparam int OCW3_RIS  = 0;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_POLL = 2;
   localparam int OCW3_SMM  = 5;
   localparam int OCW3_ESMM = 6;

   // OCW2 R/SL/EOI command encodings
   localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
   localparam logic [2:0] OCW2_SPEC_EOI   = 3'b011;
   localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;

endpackage

// File: rtl/icw_ocw_control_if.sv
// Write flags and buffered data byte from the 8259 bus-control block.
interface icw_ocw_control_if;
   logic [7:0] internal_data_bus;
   logic       write_initial_command_word_1_reset;
   logic       write_initial_command_word_2_4;
   logic       write_operation_control_word_1;
   logic       write_operation_control_word_2;
   logic       write_operation_control_word_3;

   modport master (
      output internal_data_bus,
      output write_initial_command_word_1_reset,
      output write_initial_command_word_2_4,
      output write_operation_control_word_1,
      output write_operation_control_word_2,
      output write_operation_control_word_3
   );

   modport slave (
      input internal_data_bus,
      input write_initial_command_word_1_reset,
      input write_initial_command_word_2_4,
      input write_operation_control_word_1,
      input write_operation_control_word_2,
      input write_operation_control_word_3
   );
endinterface

// File: rtl/icw_ocw_control_write_commit_detect.sv
// Registers the write flags and data byte; flags a commit on the trailing
// edge of a write, handing out the flags/data seen in its last high cycle.
module write_commit_detect
   import pic_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           data_in,
   input  logic [NUM_FLAGS-1:0] flags_in,
   output logic                 commit,
   output logic [NUM_FLAGS-1:0] flags_out,
   output logic [7:0]           data_out
);

   logic [NUM_FLAGS-1:0] flags_q, flags_d;
   logic [7:0]           data_q, data_d;

   // Sample the live bus every cycle
   always_comb begin
      flags_d = flags_in;
      data_d  = data_in;
   end

   // Reset clears the copy so a write cut by reset never commits
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= '0;
         data_q  <= '0;
      end else begin
         flags_q <= flags_d;
         data_q  <= data_d;
      end
   end

   assign commit    = (|flags_q) & ~(|flags_in);
   assign flags_out = flags_q;
   assign data_out  = data_q;

endmodule

// File: rtl/icw_ocw_control.sv
// ICW1..ICW4 initialization sequencer plus OCW1/2/3 command decode.
// All outputs are registered; pulses appear the cycle after a commit.
module icw_ocw_control
   import pic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   icw_ocw_control_if.slave bus,
   output logic       init_done,
   output logic       icw1_pulse,
   output logic       level_triggered,
   output logic       single_mode,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_config,
   output logic       auto_eoi,
   output logic       buffered_mode,
   output logic       buf_master,
   output logic       special_fully_nested,
   output logic       upm,
   output logic [7:0] interrupt_mask,
   output logic       special_mask_mode,
   output logic       read_isr_select,
   output logic       poll_cmd,
   output logic       ocw2_valid,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_level
);

   logic [NUM_FLAGS-1:0] flags_now, cf;
   logic [7:0]           cd;
   logic                 commit, wr_a0;

   // Gather the individual write flags into one vector
   always_comb begin
      flags_now              = '0;
      flags_now[FLAG_ICW1]   = bus.write_initial_command_word_1_reset;
      flags_now[FLAG_ICW2_4] = bus.write_initial_command_word_2_4;
      flags_now[FLAG_OCW1]   = bus.write_operation_control_word_1;
      flags_now[FLAG_OCW2]   = bus.write_operation_control_word_2;
      flags_now[FLAG_OCW3]   = bus.write_operation_control_word_3;
   end

   write_commit_detect u_commit (
      .clk       (clk),
      .reset     (reset),
      .data_in   (bus.internal_data_bus),
      .flags_in  (flags_now),
      .commit    (commit),
      .flags_out (cf),
      .data_out  (cd)
   );

   // ICW2..4 and OCW1 share the A0=1 decode; the state picks the meaning
   assign wr_a0 = cf[FLAG_ICW2_4] | cf[FLAG_OCW1];

   pic_state_t state_q, state_d;
   logic       ic4_q, ic4_d;
   logic       init_done_q, init_done_d, icw1_pulse_q, icw1_pulse_d;
   logic       lt_q, lt_d, sngl_q, sngl_d;
   logic [4:0] vb_q, vb_d;
   logic [7:0] cc_q, cc_d, imr_q, imr_d;
   logic       aeoi_q, aeoi_d, buf_q, buf_d, ms_q, ms_d, sfnm_q, sfnm_d, upm_q, upm_d;
   logic       smm_q, smm_d, ris_q, ris_d, poll_q, poll_d, o2v_q, o2v_d;
   logic [2:0] o2cmd_q, o2cmd_d, o2lvl_q, o2lvl_d;

   // Next-state and register update for each committed write.
   // ICW1.ADI has no consumer downstream of this block, so it is not kept.
   always_comb begin
      state_d = state_q;  ic4_d  = ic4_q;  lt_d   = lt_q;   sngl_d = sngl_q;
      vb_d    = vb_q;     cc_d   = cc_q;   imr_d  = imr_q;
      aeoi_d  = aeoi_q;   buf_d  = buf_q;  ms_d   = ms_q;   sfnm_d = sfnm_q; upm_d = upm_q;
      smm_d   = smm_q;    ris_d  = ris_q;  o2cmd_d = o2cmd_q; o2lvl_d = o2lvl_q;
      icw1_pulse_d = 1'b0;
      poll_d       = 1'b0;
      o2v_d        = 1'b0;
      if (commit) begin
         if (cf[FLAG_ICW1]) begin
            // ICW1 restarts initialization from any state
            ic4_d  = cd[ICW1_IC4];
            sngl_d = cd[ICW1_SNGL];
            lt_d   = cd[ICW1_LTIM];
            imr_d  = '0;  smm_d = 1'b0;  ris_d = 1'b0;
            aeoi_d = 1'b0; buf_d = 1'b0; ms_d = 1'b0; sfnm_d = 1'b0; upm_d = 1'b0;
            icw1_pulse_d = 1'b1;
            state_d = WAIT_ICW2;
         end else if (wr_a0) begin
            unique case (state_q)
               WAIT_ICW2: begin
                  vb_d = cd[7:3];
                  if (!sngl_q)    state_d = WAIT_ICW3;
                  else if (ic4_q) state_d = WAIT_ICW4;
                  else            state_d = READY;
               end
               WAIT_ICW3: begin
                  cc_d    = cd;
                  state_d = ic4_q ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: begin
                  upm_d   = cd[ICW4_UPM];
                  aeoi_d  = cd[ICW4_AEOI];
                  ms_d    = cd[ICW4_MS];
                  buf_d   = cd[ICW4_BUF];
                  sfnm_d  = cd[ICW4_SFNM];
                  state_d = READY;
               end
               READY:   imr_d = cd;
               default: ;
            endcase
         end else if (cf[FLAG_OCW2] && state_q == READY) begin
            o2v_d   = 1'b1;
            o2cmd_d = cd[7:5];
            o2lvl_d = cd[2:0];
         end else if (cf[FLAG_OCW3] && state_q == READY) begin
            if (cd[OCW3_RR])   ris_d  = cd[OCW3_RIS];
            if (cd[OCW3_ESMM]) smm_d  = cd[OCW3_SMM];
            if (cd[OCW3_POLL]) poll_d = 1'b1;
         end
      end
      init_done_d = (state_d == READY);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= UNINIT; ic4_q <= 1'b0; init_done_q <= 1'b0; icw1_pulse_q <= 1'b0;
         lt_q <= 1'b0; sngl_q <= 1'b0; vb_q <= '0; cc_q <= '0; imr_q <= '0;
         aeoi_q <= 1'b0; buf_q <= 1'b0; ms_q <= 1'b0; sfnm_q <= 1'b0; upm_q <= 1'b0;
         smm_q <= 1'b0; ris_q <= 1'b0; poll_q <= 1'b0; o2v_q <= 1'b0;
         o2cmd_q <= '0; o2lvl_q <= '0;
      end else begin
         state_q <= state_d; ic4_q <= ic4_d; init_done_q <= init_done_d;
         icw1_pulse_q <= icw1_pulse_d;
         lt_q <= lt_d; sngl_q <= sngl_d; vb_q <= vb_d; cc_q <= cc_d; imr_q <= imr_d;
         aeoi_q <= aeoi_d; buf_q <= buf_d; ms_q <= ms_d; sfnm_q <= sfnm_d; upm_q <= upm_d;
         smm_q <= smm_d; ris_q <= ris_d; poll_q <= poll_d; o2v_q <= o2v_d;
         o2cmd_q <= o2cmd_d; o2lvl_q <= o2lvl_d;
      end
   end

   assign init_done            = init_done_q;
   assign icw1_pulse           = icw1_pulse_q;
   assign level_triggered      = lt_q;
   assign single_mode          = sngl_q;
   assign vector_base          = vb_q;
   assign cascade_config       = cc_q;
   assign auto_eoi             = aeoi_q;
   assign buffered_mode        = buf_q;
   assign buf_master           = ms_q;
   assign special_fully_nested = sfnm_q;
   assign upm                  = upm_q;
   assign interrupt_mask       = imr_q;
   assign special_mask_mode    = smm_q;
   assign read_isr_select      = ris_q;
   assign poll_cmd             = poll_q;
   assign ocw2_valid           = o2v_q;
   assign ocw2_cmd             = o2cmd_q;
   assign ocw2_level           = o2lvl_q;

endmodule

// File: tb/tb_icw_ocw_control.sv
// Directed bench for icw_ocw_control: a behavioural model pushes expected
// output snapshots to a queue as each write is driven; they are popped and
// compared in the commit+1 cycle and the cycle after it.
module tb_icw_ocw_control;
   import pic_pkg::*;

   localparam int K_ICW1 = 0, K_A0 = 1, K_OCW1 = 2, K_OCW2 = 3, K_OCW3 = 4;
   localparam int S_UNINIT = 0, S_W2 = 1, S_W3 = 2, S_W4 = 3, S_RDY = 4;

   typedef struct packed {
      logic       icw1_pulse, poll_cmd, ocw2_valid, init_done, level_triggered, single_mode;
      logic [4:0] vector_base;
      logic [7:0] cascade_config;
      logic       auto_eoi, buffered_mode, buf_master, special_fully_nested, upm;
      logic [7:0] interrupt_mask;
      logic       special_mask_mode, read_isr_select;
      logic [2:0] ocw2_cmd, ocw2_level;
   } snap_t;

   logic clk = 1'b0;
   logic reset;
   logic       init_done, icw1_pulse, level_triggered, single_mode;
   logic [4:0] vector_base;
   logic [7:0] cascade_config, interrupt_mask;
   logic       auto_eoi, buffered_mode, buf_master, special_fully_nested, upm;
   logic       special_mask_mode, read_isr_select, poll_cmd, ocw2_valid;
   logic [2:0] ocw2_cmd, ocw2_level;

   icw_ocw_control_if bus ();

   icw_ocw_control dut (
      .clk(clk), .reset(reset), .bus(bus),
      .init_done(init_done), .icw1_pulse(icw1_pulse),
      .level_triggered(level_triggered), .single_mode(single_mode),
      .vector_base(vector_base), .cascade_config(cascade_config),
      .auto_eoi(auto_eoi), .buffered_mode(buffered_mode), .buf_master(buf_master),
      .special_fully_nested(special_fully_nested), .upm(upm),
      .interrupt_mask(interrupt_mask), .special_mask_mode(special_mask_mode),
      .read_isr_select(read_isr_select), .poll_cmd(poll_cmd),
      .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   snap_t sb_q[$];

   // Model state
   int    m_state;
   logic  m_ic4;
   snap_t m;
   int    exp_icw1_n, exp_poll_n, exp_o2v_n;
   int    seen_icw1_n = 0, seen_poll_n = 0, seen_o2v_n = 0;

   // Pulse-cycle counters, used to prove each write gives exactly one pulse
   always @(posedge clk) begin
      if (icw1_pulse === 1'b1) seen_icw1_n <= seen_icw1_n + 1;
      if (poll_cmd   === 1'b1) seen_poll_n <= seen_poll_n + 1;
      if (ocw2_valid === 1'b1) seen_o2v_n  <= seen_o2v_n + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic snap_t observe();
      snap_t o;
      o.icw1_pulse = icw1_pulse;   o.poll_cmd = poll_cmd;     o.ocw2_valid = ocw2_valid;
      o.init_done = init_done;     o.level_triggered = level_triggered;
      o.single_mode = single_mode; o.vector_base = vector_base;
      o.cascade_config = cascade_config; o.auto_eoi = auto_eoi;
      o.buffered_mode = buffered_mode;   o.buf_master = buf_master;
      o.special_fully_nested = special_fully_nested; o.upm = upm;
      o.interrupt_mask = interrupt_mask; o.special_mask_mode = special_mask_mode;
      o.read_isr_select = read_isr_select;
      o.ocw2_cmd = ocw2_cmd; o.ocw2_level = ocw2_level;
      return o;
   endfunction

   task automatic sb_check(input string ctx);
      snap_t e, o;
      if (sb_q.size() == 0) begin
         chk({ctx, ".scoreboard_empty"}, 8'd0, 8'd1);
         return;
      end
      e = sb_q.pop_front();
      o = observe();
      $display("txn %s: observed=%h expected=%h", ctx, o, e);
      chk({ctx, ".icw1_pulse"}, {7'd0, o.icw1_pulse}, {7'd0, e.icw1_pulse});
      chk({ctx, ".poll_cmd"},   {7'd0, o.poll_cmd},   {7'd0, e.poll_cmd});
      chk({ctx, ".ocw2_valid"}, {7'd0, o.ocw2_valid}, {7'd0, e.ocw2_valid});
      chk({ctx, ".init_done"},  {7'd0, o.init_done},  {7'd0, e.init_done});
      chk({ctx, ".ltim"},       {7'd0, o.level_triggered}, {7'd0, e.level_triggered});
      chk({ctx, ".sngl"},       {7'd0, o.single_mode}, {7'd0, e.single_mode});
      chk({ctx, ".vector_base"}, {3'd0, o.vector_base}, {3'd0, e.vector_base});
      chk({ctx, ".cascade"},    o.cascade_config, e.cascade_config);
      chk({ctx, ".icw4"}, {3'd0, o.auto_eoi, o.buffered_mode, o.buf_master,
                           o.special_fully_nested, o.upm},
                          {3'd0, e.auto_eoi, e.buffered_mode, e.buf_master,
                           e.special_fully_nested, e.upm});
      chk({ctx, ".imr"},        o.interrupt_mask, e.interrupt_mask);
      chk({ctx, ".smm"},        {7'd0, o.special_mask_mode}, {7'd0, e.special_mask_mode});
      chk({ctx, ".ris"},        {7'd0, o.read_isr_select}, {7'd0, e.read_isr_select});
      chk({ctx, ".ocw2_cmd"},   {5'd0, o.ocw2_cmd},   {5'd0, e.ocw2_cmd});
      chk({ctx, ".ocw2_level"}, {5'd0, o.ocw2_level}, {5'd0, e.ocw2_level});
   endtask

   task automatic model_reset();
      m = '0;
      m_state = S_UNINIT;
      m_ic4 = 1'b0;
   endtask

   // Behavioural model of one committed write, following the register map
   task automatic model_write(input int kind, input logic [7:0] d);
      m.icw1_pulse = 1'b0; m.poll_cmd = 1'b0; m.ocw2_valid = 1'b0;
      case (kind)
         K_ICW1: begin
            m_ic4 = d[0]; m.single_mode = d[1]; m.level_triggered = d[3];
            m.interrupt_mask = '0; m.special_mask_mode = 1'b0; m.read_isr_select = 1'b0;
            m.upm = 1'b0; m.auto_eoi = 1'b0; m.buf_master = 1'b0;
            m.buffered_mode = 1'b0; m.special_fully_nested = 1'b0;
            m.icw1_pulse = 1'b1; exp_icw1_n++;
            m_state = S_W2;
         end
         K_A0, K_OCW1: begin
            case (m_state)
               S_W2: begin
                  m.vector_base = d[7:3];
                  m_state = !m.single_mode ? S_W3 : (m_ic4 ? S_W4 : S_RDY);
               end
               S_W3: begin
                  m.cascade_config = d;
                  m_state = m_ic4 ? S_W4 : S_RDY;
               end
               S_W4: begin
                  m.upm = d[0]; m.auto_eoi = d[1]; m.buf_master = d[2];
                  m.buffered_mode = d[3]; m.special_fully_nested = d[4];
                  m_state = S_RDY;
               end
               S_RDY: m.interrupt_mask = d;
               default: ;
            endcase
         end
         K_OCW2: if (m_state == S_RDY) begin
            m.ocw2_valid = 1'b1; exp_o2v_n++;
            m.ocw2_cmd = d[7:5]; m.ocw2_level = d[2:0];
         end
         K_OCW3: if (m_state == S_RDY) begin
            if (d[1]) m.read_isr_select = d[0];
            if (d[6]) m.special_mask_mode = d[5];
            if (d[2]) begin m.poll_cmd = 1'b1; exp_poll_n++; end
         end
         default: ;
      endcase
      m.init_done = (m_state == S_RDY);
   endtask

   task automatic set_flag(input int kind, input logic v);
      case (kind)
         K_ICW1: bus.write_initial_command_word_1_reset = v;
         K_A0:   bus.write_initial_command_word_2_4 = v;
         K_OCW1: bus.write_operation_control_word_1 = v;
         K_OCW2: bus.write_operation_control_word_2 = v;
         default: bus.write_operation_control_word_3 = v;
      endcase
   endtask

   // Drive one write held for `hold` clocks, then check commit+1 and commit+2
   task automatic do_write(input string ctx, input int kind, input logic [7:0] d,
                           input int hold);
      snap_t e;
      model_write(kind, d);
      e = m;
      sb_q.push_back(e);
      e.icw1_pulse = 1'b0; e.poll_cmd = 1'b0; e.ocw2_valid = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      bus.internal_data_bus = d;
      set_flag(kind, 1'b1);
      repeat (hold) @(negedge clk);
      set_flag(kind, 1'b0);
      bus.internal_data_bus = 8'($urandom);  // junk after the write must not be used
      @(negedge clk);
      sb_check({ctx, "@c+1"});
      @(negedge clk);
      sb_check({ctx, "@c+2"});
   endtask

   initial begin
      reset = 1'b1;
      bus.internal_data_bus = 8'h00;
      bus.write_initial_command_word_1_reset = 1'b0;
      bus.write_initial_command_word_2_4 = 1'b0;
      bus.write_operation_control_word_1 = 1'b0;
      bus.write_operation_control_word_2 = 1'b0;
      bus.write_operation_control_word_3 = 1'b0;
      exp_icw1_n = 0; exp_poll_n = 0; exp_o2v_n = 0;
      model_reset();
      repeat (3) @(negedge clk);
      sb_q.push_back(m);
      sb_check("reset");
      reset = 1'b0;

      // A0=1 write before any ICW1 is ignored
      do_write("uninit_a0", K_A0, 8'h55, 2);

      // Single, with ICW4: ICW3 skipped
      do_write("s1_icw1", K_ICW1, 8'h13, 2);
      do_write("s1_icw2", K_A0,   8'h48, 2);
      chk("s1.not_ready_after_icw2", {7'd0, init_done}, 8'd0);
      do_write("s1_icw4", K_A0,   8'h03, 3);
      chk("s1.vector_base", {3'd0, vector_base}, 8'h09);
      chk("s1.aeoi_upm", {6'd0, auto_eoi, upm}, 8'h03);
      chk("s1.init_done", {7'd0, init_done}, 8'd1);

      // Cascade, with ICW3 and ICW4, then OCW1
      do_write("s2_icw1", K_ICW1, 8'h11, 2);
      do_write("s2_icw2", K_A0,   8'h20, 2);
      do_write("s2_icw3", K_A0,   8'h04, 2);
      chk("s2.cascade", cascade_config, 8'h04);
      do_write("s2_icw4", K_A0,   8'h01, 2);
      do_write("s2_ocw1", K_OCW1, 8'hF0, 2);
      chk("s2.imr", interrupt_mask, 8'hF0);

      // No ICW4, level triggered
      do_write("s3_icw1", K_ICW1, 8'h1A, 2);
      do_write("s3_icw2", K_A0,   8'h00, 2);
      chk("s3.init_done", {7'd0, init_done}, 8'd1);
      do_write("s3_ocw1", K_A0,   8'h0F, 2);

      // OCW2/OCW3 in READY
      do_write("ocw2_spec_eoi", K_OCW2, 8'h63, 2);
      chk("ocw2.cmd_enc", {5'd0, ocw2_cmd}, {5'd0, OCW2_SPEC_EOI});
      do_write("ocw3_read_isr", K_OCW3, 8'h0B, 2);
      do_write("ocw3_poll",     K_OCW3, 8'h0C, 2);
      do_write("ocw3_smm",      K_OCW3, 8'h68, 2);
      do_write("ocw2_held5",    K_OCW2, 8'hA5, 5);

      // ICW1 restarts from WAIT_ICW3; OCW2 then ignored in WAIT_ICW2
      do_write("r_icw1", K_ICW1, 8'h11, 2);
      do_write("r_icw2", K_A0,   8'h20, 2);
      do_write("r_icw1_again", K_ICW1, 8'h11, 2);
      do_write("r_ocw2_ignored", K_OCW2, 8'h20, 2);
      do_write("r_icw2_b", K_A0, 8'h38, 2);  // back to WAIT_ICW3, proves WAIT_ICW2

      // Reset asserted mid-write: the write must never commit
      @(negedge clk);
      bus.internal_data_bus = 8'h13;
      bus.write_initial_command_word_1_reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.write_initial_command_word_1_reset = 1'b0;
      model_reset();
      sb_q.push_back(m);
      sb_q.push_back(m);
      @(negedge clk);
      sb_check("rst_mid_write@1");
      @(negedge clk);
      sb_check("rst_mid_write@2");

      repeat (2) @(negedge clk);
      chk("pulses.icw1_count", 8'(seen_icw1_n), 8'(exp_icw1_n));
      chk("pulses.poll_count", 8'(seen_poll_n), 8'(exp_poll_n));
      chk("pulses.ocw2_count", 8'(seen_o2v_n),  8'(exp_o2v_n));
      chk("scoreboard.drained", 8'(sb_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
